write_back_top: RTL and testbench

WRITE_BACK_TOP -- requirements
Module: write_back_top

---
 rtl/utils_top.sv | 36 +++
 rtl/reg_file_2r1w.sv | 42 ++++
 rtl/write_back_top.sv | 87 ++++++++
 tb/tb_write_back_top.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/utils_top.sv
// Shared constants and types for the write-back stage: opcode encodings,
// register-file geometry and the MEM/WB pipeline entry layout.
package utils_top;

  localparam int XLEN     = 32;
  localparam int RF_DEPTH = 32;
  localparam int RF_AW    = 5;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  typedef struct packed {
    logic            vld;
    logic [XLEN-1:0] dat;
    logic [XLEN-1:0] inst;
    logic [XLEN-1:0] pc;
  } wb_entry_t;

  typedef struct packed {
    logic             writes_rd;
    logic [RF_AW-1:0] rd;
  } wb_decode_t;

  // Stores and branches have no destination; their bits [11:7] are immediate.
  function automatic wb_decode_t decode_inst(input logic [XLEN-1:0] inst);
    wb_decode_t dec;
    dec.writes_rd = (inst[6:0] != OP_STORE) && (inst[6:0] != OP_BRANCH)
                    && (inst[31:12] == inst[31:12]);
    dec.rd        = inst[11:7];
    return dec;
  endfunction

endpackage

// File: rtl/reg_file_2r1w.sv
// Integer register file: two combinational read ports, one synchronous write
// port, x0 hard-wired to zero, same-cycle write-through bypass on both reads.
module reg_file_2r1w
  import utils_top::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [RF_AW-1:0] waddr_i,
  input  logic [XLEN-1:0]  wdata_i,
  input  logic [RF_AW-1:0] raddr1_i,
  input  logic [RF_AW-1:0] raddr2_i,
  output logic [XLEN-1:0]  rdata1_o,
  output logic [XLEN-1:0]  rdata2_o
);

  logic [XLEN-1:0] regs_q [RF_DEPTH];
  logic            wr_ok;

  assign wr_ok = we_i && (waddr_i != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < RF_DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_ok) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // A pending write is forwarded so decode sees it without waiting an edge.
  always_comb begin
    rdata1_o = regs_q[raddr1_i];
    rdata2_o = regs_q[raddr2_i];
    if (wr_ok && (raddr1_i == waddr_i)) rdata1_o = wdata_i;
    if (wr_ok && (raddr2_i == waddr_i)) rdata2_o = wdata_i;
    if (raddr1_i == '0) rdata1_o = '0;
    if (raddr2_i == '0) rdata2_o = '0;
  end

endmodule

// File: rtl/write_back_top.sv
// Write-back stage: MEM/WB pipeline register, register-file write decode,
// forwarding outputs to decode and the 64-bit retired-instruction counter.
module write_back_top
  import utils_top::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_vld,
  input  logic [XLEN-1:0]   mem_dat,
  input  logic [XLEN-1:0]   mem_inst,
  input  logic [XLEN-1:0]   mem_pc,
  input  logic              hold,
  input  logic              flush,
  input  logic [RF_AW-1:0]  id_rs1,
  input  logic [RF_AW-1:0]  id_rs2,
  output logic [XLEN-1:0]   id_rd1,
  output logic [XLEN-1:0]   id_rd2,
  output logic              id_fwd_we,
  output logic [RF_AW-1:0]  id_fwd_dst,
  output logic [XLEN-1:0]   id_fwd_dat,
  output logic              ret_vld,
  output logic [XLEN-1:0]   ret_pc,
  output logic [63:0]       instret
);

  wb_entry_t  entry_q, entry_d;
  wb_decode_t dec;
  logic [63:0] instret_q, instret_d;
  logic        retire;
  logic        wr_en;

  // flush only drops the valid bit; hold freezes the whole entry.
  always_comb begin
    entry_d = entry_q;
    if (flush) begin
      entry_d.vld = 1'b0;
    end else if (!hold) begin
      entry_d.vld  = mem_vld;
      entry_d.dat  = mem_dat;
      entry_d.inst = mem_inst;
      entry_d.pc   = mem_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q <= '0;
    end else begin
      entry_q <= entry_d;
    end
  end

  // Gating with rst_n keeps a live entry from retiring while reset is held.
  assign dec    = decode_inst(entry_q.inst);
  assign retire = rst_n && entry_q.vld && !hold && !flush;
  assign wr_en  = retire && dec.writes_rd && (dec.rd != '0);

  assign instret_d = instret_q + {63'd0, retire};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  reg_file_2r1w u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .we_i     (wr_en),
    .waddr_i  (dec.rd),
    .wdata_i  (entry_q.dat),
    .raddr1_i (id_rs1),
    .raddr2_i (id_rs2),
    .rdata1_o (id_rd1),
    .rdata2_o (id_rd2)
  );

  assign id_fwd_we  = wr_en;
  assign id_fwd_dst = dec.rd;
  assign id_fwd_dat = entry_q.dat;
  assign ret_vld    = retire;
  assign ret_pc     = entry_q.pc;
  assign instret    = instret_q;

endmodule

// File: tb/tb_write_back_top.sv
// Directed bench for write_back_top: reset, bypass, x0, stores/branches,
// hold/flush interaction, counter wrap and reset mid-entry.
module tb_write_back_top;

  logic        clk;
  logic        rst_n;
  logic        mem_vld;
  logic [31:0] mem_dat;
  logic [31:0] mem_inst;
  logic [31:0] mem_pc;
  logic        hold;
  logic        flush;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [31:0] id_rd1;
  logic [31:0] id_rd2;
  logic        id_fwd_we;
  logic [4:0]  id_fwd_dst;
  logic [31:0] id_fwd_dat;
  logic        ret_vld;
  logic [31:0] ret_pc;
  logic [63:0] instret;

  int nTests;
  int nFail;

  write_back_top dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_vld    (mem_vld),
    .mem_dat    (mem_dat),
    .mem_inst   (mem_inst),
    .mem_pc     (mem_pc),
    .hold       (hold),
    .flush      (flush),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd1     (id_rd1),
    .id_rd2     (id_rd2),
    .id_fwd_we  (id_fwd_we),
    .id_fwd_dst (id_fwd_dst),
    .id_fwd_dat (id_fwd_dat),
    .ret_vld    (ret_vld),
    .ret_pc     (ret_pc),
    .instret    (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic vld, input logic [31:0] dat,
                               input logic [31:0] inst, input logic [31:0] pc);
    mem_vld  = vld;
    mem_dat  = dat;
    mem_inst = inst;
    mem_pc   = pc;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    nTests++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    nTests = 0;
    nFail  = 0;
    rst_n  = 1'b0;
    hold   = 1'b0;
    flush  = 1'b0;
    id_rs1 = 5'd5;
    id_rs2 = 5'd31;
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);

    tick();
    tick();
    checkOutput("rst_ret_vld", ret_vld, 1'b0);
    checkOutput("rst_fwd_we", id_fwd_we, 1'b0);
    checkOutput("rst_instret", instret, 64'd0);

    rst_n = 1'b1;
    tick();
    checkOutput("post_rst_rd1", id_rd1, 32'h0);
    checkOutput("post_rst_rd2", id_rd2, 32'h0);

    // ADDI x5 -> 0x1234, bypass then register read
    applyStimulus(1'b1, 32'h0000_1234, 32'h0000_0293, 32'h0000_0100);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
    id_rs2 = 5'd5;
    #1;
    checkOutput("addi_fwd_we", id_fwd_we, 1'b1);
    checkOutput("addi_fwd_dst", id_fwd_dst, 5'd5);
    checkOutput("addi_fwd_dat", id_fwd_dat, 32'h0000_1234);
    checkOutput("addi_bypass_rd1", id_rd1, 32'h0000_1234);
    checkOutput("addi_ret_vld", ret_vld, 1'b1);
    checkOutput("addi_ret_pc", ret_pc, 32'h0000_0100);
    checkOutput("addi_instret_pre", instret, 64'd0);
    tick();
    checkOutput("addi_instret", instret, 64'd1);
    checkOutput("addi_rf_rd1", id_rd1, 32'h0000_1234);
    checkOutput("addi_rf_rd2_same", id_rd2, 32'h0000_1234);
    checkOutput("addi_idle_we", id_fwd_we, 1'b0);
    checkOutput("addi_idle_ret", ret_vld, 1'b0);

    // write to x0 is suppressed but still retires
    applyStimulus(1'b1, 32'hDEAD_BEEF, 32'h0000_0013, 32'h0000_0104);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
    id_rs1 = 5'd0;
    #1;
    checkOutput("x0_fwd_we", id_fwd_we, 1'b0);
    checkOutput("x0_ret_vld", ret_vld, 1'b1);
    checkOutput("x0_rd1", id_rd1, 32'h0);
    tick();
    checkOutput("x0_instret", instret, 64'd2);
    checkOutput("x0_rd1_after", id_rd1, 32'h0);

    // STORE (bits 11:7 = 5) then BRANCH (bits 11:7 = 7)
    id_rs1 = 5'd5;
    id_rs2 = 5'd7;
    applyStimulus(1'b1, 32'h0000_AAAA, 32'h0000_02A3, 32'h0000_0108);
    tick();
    applyStimulus(1'b1, 32'h0000_BBBB, 32'h0000_03E3, 32'h0000_010C);
    #1;
    checkOutput("st_fwd_we", id_fwd_we, 1'b0);
    checkOutput("st_ret_vld", ret_vld, 1'b1);
    checkOutput("st_ret_pc", ret_pc, 32'h0000_0108);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkOutput("br_fwd_we", id_fwd_we, 1'b0);
    checkOutput("br_ret_vld", ret_vld, 1'b1);
    checkOutput("br_ret_pc", ret_pc, 32'h0000_010C);
    checkOutput("st_instret", instret, 64'd3);
    tick();
    checkOutput("br_instret", instret, 64'd4);
    checkOutput("stbr_x5", id_rd1, 32'h0000_1234);
    checkOutput("stbr_x7", id_rd2, 32'h0);

    // x7 = 0x55 held for three cycles, then released
    applyStimulus(1'b1, 32'h0000_0055, 32'h0000_0393, 32'h0000_0110);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
    hold = 1'b1;
    #1;
    checkOutput("hold_ret_vld", ret_vld, 1'b0);
    checkOutput("hold_fwd_we", id_fwd_we, 1'b0);
    tick();
    tick();
    tick();
    checkOutput("hold_x7", id_rd2, 32'h0);
    checkOutput("hold_instret", instret, 64'd4);
    hold = 1'b0;
    #1;
    checkOutput("unhold_ret_vld", ret_vld, 1'b1);
    checkOutput("unhold_fwd_we", id_fwd_we, 1'b1);
    checkOutput("unhold_bypass", id_rd2, 32'h0000_0055);
    tick();
    checkOutput("unhold_instret", instret, 64'd5);
    checkOutput("unhold_ret_after", ret_vld, 1'b0);
    checkOutput("unhold_x7", id_rd2, 32'h0000_0055);
    tick();
    checkOutput("unhold_once", instret, 64'd5);

    // flush during hold drops the x7 = 0x66 entry
    applyStimulus(1'b1, 32'h0000_0066, 32'h0000_0393, 32'h0000_0114);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
    hold = 1'b1;
    tick();
    flush = 1'b1;
    #1;
    checkOutput("flush_ret_vld", ret_vld, 1'b0);
    checkOutput("flush_fwd_we", id_fwd_we, 1'b0);
    tick();
    flush = 1'b0;
    hold  = 1'b0;
    #1;
    checkOutput("flush_dropped", ret_vld, 1'b0);
    tick();
    checkOutput("flush_instret", instret, 64'd5);
    checkOutput("flush_x7", id_rd2, 32'h0000_0055);

    // instret wrap from all-ones
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    checkOutput("wrap_preload", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    release dut.instret_q;
    applyStimulus(1'b1, 32'h0000_0099, 32'h0000_0493, 32'h0000_0118);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkOutput("wrap_ret_vld", ret_vld, 1'b1);
    checkOutput("wrap_hold_val", instret, 64'hFFFF_FFFF_FFFF_FFFF);
    tick();
    checkOutput("wrap_zero", instret, 64'd0);

    // reset asserted while an x3 write is pending
    id_rs1 = 5'd3;
    id_rs2 = 5'd5;
    applyStimulus(1'b1, 32'h0000_0033, 32'h0000_0193, 32'h0000_011C);
    tick();
    applyStimulus(1'b0, 32'h0, 32'h0, 32'h0);
    #1;
    checkOutput("prerst_ret_vld", ret_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_ret_vld", ret_vld, 1'b0);
    checkOutput("midrst_fwd_we", id_fwd_we, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("midrst_instret", instret, 64'd0);
    checkOutput("midrst_x3", id_rd1, 32'h0);
    checkOutput("midrst_x5", id_rd2, 32'h0);
    checkOutput("midrst_ret_after", ret_vld, 1'b0);
    tick();
    checkOutput("midrst_x3_later", id_rd1, 32'h0);
    checkOutput("midrst_instret_later", instret, 64'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
